// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// Samples an asynchronous serial line through a 2-flop synchronizer, recovers
// bytes LSB-first using a 3-sample majority vote at mid-bit, and presents each
// byte with a one-cycle write strobe suitable for a ring buffer write port.
// Ports:
//   clock              - system clock, rising edge
//   reset              - asynchronous active-low reset
//   rx                 - serial line, asynchronous, idle high
//   read_data[7:0]     - last correctly received byte
//   write_clock_enable - one-cycle pulse when read_data takes a new byte
//   framing_error      - one-cycle pulse when the stop bit is sampled low
//   line_break         - high while waiting for the line to return high after a framing error
//   busy               - high whenever the receiver is not idle
module uart_rx #(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] read_data,
  output logic       write_clock_enable,
  output logic       framing_error,
  output logic       line_break,
  output logic       busy
);

  localparam int BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF      = BIT_TICKS / 2;
  localparam int TW        = $clog2(BIT_TICKS);

  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_S0   = TW'(HALF - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(HALF);
  localparam logic [TW-1:0] TICK_DEC  = TW'(HALF + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

  generate
    if (BIT_TICKS < 8) begin : g_bit_ticks_check
      $error("uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // 2-of-3 majority used to decide every bit value.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic          sync1_r;
  logic          rx_s;
  state_t        state_r, state_nx_s;
  logic [TW-1:0] tick_r, tick_nx_s;
  logic [3:0]    bit_idx_r, bit_idx_nx_s;
  logic [1:0]    smp_r, smp_nx_s;
  logic [7:0]    shift_r, shift_nx_s;
  logic [7:0]    read_data_r, read_data_nx_s;
  logic          wce_r, wce_nx_s;
  logic          fe_r, fe_nx_s;
  logic          line_break_r;
  logic          busy_r;
  logic          vote_s;

  // Two-flop synchronizer; resets high so a reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
    end
  end

  // The third sample is the live synchronized line at the decision tick.
  assign vote_s = majority3(smp_r[0], smp_r[1], rx_s);

  // Next-state and datapath decode.
  always_comb begin
    state_nx_s     = state_r;
    bit_idx_nx_s   = bit_idx_r;
    shift_nx_s     = shift_r;
    read_data_nx_s = read_data_r;
    wce_nx_s       = 1'b0;
    fe_nx_s        = 1'b0;
    smp_nx_s       = smp_r;

    if (tick_r == TICK_LAST) begin
      tick_nx_s = TICK_ZERO;
    end else begin
      tick_nx_s = tick_r + TICK_ONE;
    end

    if (tick_r == TICK_S0) begin
      smp_nx_s[0] = rx_s;
    end else if (tick_r == TICK_S1) begin
      smp_nx_s[1] = rx_s;
    end else begin
      smp_nx_s = smp_r;
    end

    case (state_r)
      S_IDLE: begin
        // The cycle that sees the low line counts as tick 0 of the start bit.
        if (!rx_s) begin
          state_nx_s = S_START;
          tick_nx_s  = TICK_ONE;
        end else begin
          tick_nx_s  = TICK_ZERO;
        end
      end
      S_START: begin
        if ((tick_r == TICK_DEC) && vote_s) begin
          state_nx_s = S_IDLE;
          tick_nx_s  = TICK_ZERO;
        end else if (tick_r == TICK_LAST) begin
          state_nx_s   = S_DATA;
          bit_idx_nx_s = 4'd1;
        end else begin
          state_nx_s = S_START;
        end
      end
      S_DATA: begin
        // Shift in from the MSB so the first data bit lands in bit 0.
        if (tick_r == TICK_DEC) begin
          shift_nx_s = {vote_s, shift_r[7:1]};
        end else begin
          shift_nx_s = shift_r;
        end
        if (tick_r == TICK_LAST) begin
          if (bit_idx_r == 4'd8) begin
            state_nx_s = S_STOP;
          end else begin
            bit_idx_nx_s = bit_idx_r + 4'd1;
          end
        end else begin
          bit_idx_nx_s = bit_idx_r;
        end
      end
      S_STOP: begin
        // Leave at mid-stop so a start edge at the nominal stop end is caught.
        if (tick_r == TICK_DEC) begin
          tick_nx_s = TICK_ZERO;
          if (vote_s) begin
            state_nx_s     = S_IDLE;
            read_data_nx_s = shift_r;
            wce_nx_s       = 1'b1;
          end else begin
            state_nx_s = S_BREAK;
            fe_nx_s    = 1'b1;
          end
        end else begin
          state_nx_s = S_STOP;
        end
      end
      S_BREAK: begin
        tick_nx_s = TICK_ZERO;
        if (rx_s) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_BREAK;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        tick_nx_s  = TICK_ZERO;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath and registered outputs; level outputs follow the next state so
  // they line up exactly with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_r       <= TICK_ZERO;
      bit_idx_r    <= 4'd0;
      smp_r        <= 2'b11;
      shift_r      <= 8'h00;
      read_data_r  <= 8'h00;
      wce_r        <= 1'b0;
      fe_r         <= 1'b0;
      line_break_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      tick_r       <= tick_nx_s;
      bit_idx_r    <= bit_idx_nx_s;
      smp_r        <= smp_nx_s;
      shift_r      <= shift_nx_s;
      read_data_r  <= read_data_nx_s;
      wce_r        <= wce_nx_s;
      fe_r         <= fe_nx_s;
      line_break_r <= (state_nx_s == S_BREAK);
      busy_r       <= (state_nx_s != S_IDLE);
    end
  end

  assign read_data          = read_data_r;
  assign write_clock_enable = wce_r;
  assign framing_error      = fe_r;
  assign line_break         = line_break_r;
  assign busy               = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives serial frames built from byte values and bit
// periods, records every strobe with its cycle number, and compares against
// expectations computed from frame start times and the byte values sent.
module tb_uart_rx;

  localparam int CLK_HZ = 12000000;
  localparam int BAUD   = 115200;
  localparam int BT     = CLK_HZ / BAUD;
  localparam int HB     = BT / 2;
  // pin edge -> 2 sync cycles -> T; strobe at T + 9*BT + HB + 2
  localparam int PULSE_OFS = 2 + 9 * BT + HB + 2;
  localparam int BIG = 1000000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] read_data;
  logic       write_clock_enable;
  logic       framing_error;
  logic       line_break;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int overlap_cnt = 0;
  int         wce_cyc_q[$];
  logic [7:0] wce_dat_q[$];
  int         fe_cyc_q[$];

  uart_rx dut (
    .clock(clock), .reset(reset), .rx(rx), .read_data(read_data),
    .write_clock_enable(write_clock_enable), .framing_error(framing_error),
    .line_break(line_break), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (write_clock_enable) begin
      wce_cyc_q.push_back(cyc);
      wce_dat_q.push_back(read_data);
    end
    if (framing_error) fe_cyc_q.push_back(cyc);
    if (write_clock_enable && framing_error) overlap_cnt++;
  end

  task automatic clear_mon();
    wce_cyc_q.delete();
    wce_dat_q.delete();
    fe_cyc_q.delete();
  endtask

  // Called and returns 1 time unit after a rising edge.
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive one frame from the current cycle; c is the cycle the start bit begins.
  task automatic drive_frame(input logic [7:0] b, input int bt, input logic stop_v,
                             input int glitch_at, input int stop_after, output int c);
    logic lv;
    int n;
    c = cyc;
    for (int k = 0; k < 10 * bt && k < stop_after; k++) begin
      n = k / bt;
      if (n == 0) lv = 1'b0;
      else if (n <= 8) lv = b[n-1];
      else lv = stop_v;
      if (k == glitch_at) lv = ~lv;
      rx = lv;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    wait_cycles(3);
    @(negedge clock);
    total++; if (read_data !== 8'h00) begin bad++; $display("FAIL reset_read_data: got %h want 00", read_data); end
    total++; if (write_clock_enable !== 1'b0) begin bad++; $display("FAIL reset_wce: got %b want 0", write_clock_enable); end
    total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL reset_fe: got %b want 0", framing_error); end
    total++; if (line_break !== 1'b0) begin bad++; $display("FAIL reset_lb: got %b want 0", line_break); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_single();
    int c;
    clear_mon();
    drive_frame(8'h68, BT, 1'b1, -1, BIG, c);
    rx = 1'b1;
    wait_cycles(20);
    total++; if (wce_cyc_q.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", wce_cyc_q.size()); end
    if (wce_cyc_q.size() >= 1) begin
      total++; if (wce_cyc_q[0] !== c + PULSE_OFS) begin bad++; $display("FAIL single_latency: got %0d want %0d", wce_cyc_q[0] - c, PULSE_OFS); end
      total++; if (wce_dat_q[0] !== 8'h68) begin bad++; $display("FAIL single_data: got %h want 68", wce_dat_q[0]); end
    end
    total++; if (fe_cyc_q.size() !== 0) begin bad++; $display("FAIL single_fe: got %0d want 0", fe_cyc_q.size()); end
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [6];
    int c, c0;
    msg = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21};
    c0 = 0;
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      drive_frame(msg[i], BT, 1'b1, -1, BIG, c);
      if (i == 0) c0 = c;
    end
    rx = 1'b1;
    wait_cycles(20);
    total++; if (wce_cyc_q.size() !== 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", wce_cyc_q.size()); end
    for (int i = 0; i < 6 && i < wce_cyc_q.size(); i++) begin
      total++; if (wce_dat_q[i] !== msg[i]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, wce_dat_q[i], msg[i]); end
      total++; if (wce_cyc_q[i] !== c0 + PULSE_OFS + i * 10 * BT) begin bad++; $display("FAIL b2b_time[%0d]: got %0d want %0d", i, wce_cyc_q[i] - c0, PULSE_OFS + i * 10 * BT); end
    end
    total++; if (fe_cyc_q.size() !== 0) begin bad++; $display("FAIL b2b_fe: got %0d want 0", fe_cyc_q.size()); end
  endtask

  task automatic test_framing();
    int c;
    clear_mon();
    drive_frame(8'h55, BT, 1'b0, -1, BIG, c);
    rx = 1'b0;
    wait_cycles(2000);
    @(negedge clock);
    total++; if (line_break !== 1'b1) begin bad++; $display("FAIL break_level: got %b want 1", line_break); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy: got %b want 1", busy); end
    total++; if (fe_cyc_q.size() !== 1) begin bad++; $display("FAIL fe_count: got %0d want 1", fe_cyc_q.size()); end
    if (fe_cyc_q.size() >= 1) begin
      total++; if (fe_cyc_q[0] !== c + PULSE_OFS) begin bad++; $display("FAIL fe_time: got %0d want %0d", fe_cyc_q[0] - c, PULSE_OFS); end
    end
    total++; if (wce_cyc_q.size() !== 0) begin bad++; $display("FAIL fe_wce: got %0d want 0", wce_cyc_q.size()); end
    total++; if (read_data !== 8'h21) begin bad++; $display("FAIL fe_read_data: got %h want 21", read_data); end
    @(posedge clock);
    #1;
    rx = 1'b1;
    wait_cycles(2);
    @(negedge clock);
    total++; if (line_break !== 1'b1) begin bad++; $display("FAIL break_hold: got %b want 1", line_break); end
    @(posedge clock);
    #1;
    @(negedge clock);
    total++; if (line_break !== 1'b0) begin bad++; $display("FAIL break_release: got %b want 0", line_break); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_release_busy: got %b want 0", busy); end
    @(posedge clock);
    #1;
    wait_cycles(10);
  endtask

  task automatic test_false_start();
    clear_mon();
    rx = 1'b0;
    wait_cycles(30);
    rx = 1'b1;
    wait_cycles(10);
    @(negedge clock);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL false_start_busy: got %b want 1", busy); end
    @(posedge clock);
    #1;
    wait_cycles(60);
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL false_start_idle: got %b want 0", busy); end
    total++; if (wce_cyc_q.size() + fe_cyc_q.size() !== 0) begin bad++; $display("FAIL false_start_flags: got %0d want 0", wce_cyc_q.size() + fe_cyc_q.size()); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_glitch();
    int c;
    clear_mon();
    drive_frame(8'hA5, BT, 1'b1, 3 * BT + HB, BIG, c);
    rx = 1'b1;
    wait_cycles(20);
    total++; if (wce_cyc_q.size() !== 1) begin bad++; $display("FAIL glitch_count: got %0d want 1", wce_cyc_q.size()); end
    if (wce_cyc_q.size() >= 1) begin
      total++; if (wce_dat_q[0] !== 8'hA5) begin bad++; $display("FAIL glitch_data: got %h want a5", wce_dat_q[0]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int c;
    clear_mon();
    drive_frame(8'hFF, BT, 1'b1, -1, 4 * BT + 50, c);
    rx = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    total++; if ({read_data, write_clock_enable, framing_error, line_break, busy} !== 12'h000) begin
      bad++; $display("FAIL midreset_outputs: got %h want 000", {read_data, write_clock_enable, framing_error, line_break, busy});
    end
    @(posedge clock);
    #1;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1500);
    total++; if (wce_cyc_q.size() + fe_cyc_q.size() !== 0) begin bad++; $display("FAIL midreset_aborted: got %0d want 0", wce_cyc_q.size() + fe_cyc_q.size()); end
    drive_frame(8'h3C, BT, 1'b1, -1, BIG, c);
    wait_cycles(20);
    total++; if (wce_cyc_q.size() !== 1) begin bad++; $display("FAIL midreset_count: got %0d want 1", wce_cyc_q.size()); end
    if (wce_cyc_q.size() >= 1) begin
      total++; if (wce_dat_q[0] !== 8'h3C) begin bad++; $display("FAIL midreset_data: got %h want 3c", wce_dat_q[0]); end
      total++; if (wce_cyc_q[0] !== c + PULSE_OFS) begin bad++; $display("FAIL midreset_time: got %0d want %0d", wce_cyc_q[0] - c, PULSE_OFS); end
    end
  endtask

  task automatic test_baud_tolerance();
    int c;
    int rates [2];
    rates = '{101, 107};
    for (int r = 0; r < 2; r++) begin
      clear_mon();
      drive_frame(8'hC3, rates[r], 1'b1, -1, BIG, c);
      wait_cycles(20);
      total++; if (wce_cyc_q.size() !== 1) begin bad++; $display("FAIL baud%0d_count: got %0d want 1", rates[r], wce_cyc_q.size()); end
      if (wce_cyc_q.size() >= 1) begin
        total++; if (wce_dat_q[0] !== 8'hC3) begin bad++; $display("FAIL baud%0d_data: got %h want c3", rates[r], wce_dat_q[0]); end
      end
      total++; if (fe_cyc_q.size() !== 0) begin bad++; $display("FAIL baud%0d_fe: got %0d want 0", rates[r], fe_cyc_q.size()); end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] exp_b [$];
    int exp_c [$];
    logic [7:0] b;
    int bt, gap, c;
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom_range(0, 255));
      bt  = $urandom_range(101, 107);
      gap = $urandom_range(0, 40);
      drive_frame(b, bt, 1'b1, -1, BIG, c);
      exp_b.push_back(b);
      exp_c.push_back(c + PULSE_OFS);
      wait_cycles(gap);
    end
    wait_cycles(20);
    total++; if (wce_cyc_q.size() !== exp_b.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", wce_cyc_q.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < wce_cyc_q.size(); i++) begin
      total++; if (wce_dat_q[i] !== exp_b[i]) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, wce_dat_q[i], exp_b[i]); end
      total++; if (wce_cyc_q[i] !== exp_c[i]) begin bad++; $display("FAIL rand_time[%0d]: got %0d want %0d", i, wce_cyc_q[i], exp_c[i]); end
    end
    total++; if (fe_cyc_q.size() !== 0) begin bad++; $display("FAIL rand_fe: got %0d want 0", fe_cyc_q.size()); end
  endtask

  task automatic test_exclusive();
    total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL wce_fe_overlap: got %0d want 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_false_start();
    test_glitch();
    test_reset_mid_frame();
    test_baud_tolerance();
    test_random_frames();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
